// File: rtl/mips_pkg.sv
// Shared MIPS datapath widths, ALUOp and field encodings, and the ID/EX payload record.
package mips_pkg;

  localparam int NB_DATA    = 32;
  localparam int NB_REG     = 5;
  localparam int NB_FUNCT   = 6;
  localparam int NB_ALU_OP  = 4;
  localparam int NB_SHAMT   = 5;
  localparam int NB_CNT_DEF = 16;

  // ALUOp values understood by the EX ALU-control stage
  localparam logic [NB_ALU_OP-1:0] ALU_OP_LOAD_STORE = 4'b0000;
  localparam logic [NB_ALU_OP-1:0] ALU_OP_BRANCH     = 4'b0001;
  localparam logic [NB_ALU_OP-1:0] ALU_OP_R_TYPE     = 4'b0010;
  localparam logic [NB_ALU_OP-1:0] ALU_OP_ADDI       = 4'b0011;
  localparam logic [NB_ALU_OP-1:0] ALU_OP_ANDI       = 4'b0100;
  localparam logic [NB_ALU_OP-1:0] ALU_OP_ORI        = 4'b0101;
  localparam logic [NB_ALU_OP-1:0] ALU_OP_XORI       = 4'b0110;
  localparam logic [NB_ALU_OP-1:0] ALU_OP_LUI        = 4'b0111;
  localparam logic [NB_ALU_OP-1:0] ALU_OP_SLTI       = 4'b1000;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b11;

  // All-zero value of this record is the bubble
  typedef struct packed {
    logic                 valid;
    logic [NB_DATA-1:0]   pc_plus4;
    logic [NB_DATA-1:0]   rs_data;
    logic [NB_DATA-1:0]   rt_data;
    logic [NB_DATA-1:0]   imm_ext;
    logic [NB_SHAMT-1:0]  shamt;
    logic [NB_FUNCT-1:0]  funct;
    logic [NB_REG-1:0]    rs_addr;
    logic [NB_REG-1:0]    rt_addr;
    logic [NB_REG-1:0]    rd_addr;
    logic [NB_ALU_OP-1:0] alu_op;
    logic                 alu_src;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 reg_write;
    logic                 mem_unsigned;
    logic [1:0]           reg_dst;
    logic [1:0]           mem_width;
  } id_ex_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID-side operand/control fields into the ID/EX register and their registered EX-side copies.
// No handshake: the register loads on every enabled edge; flush/stall/enable arrive as plain ports.
interface id_ex_pipe_reg_if
  import mips_pkg::*;
#(
  parameter int NB_CNT = NB_CNT_DEF
);

  logic                 i_valid,    o_valid;
  logic [NB_DATA-1:0]   i_pc_plus4, o_pc_plus4;
  logic [NB_DATA-1:0]   i_rs_data,  o_rs_data;
  logic [NB_DATA-1:0]   i_rt_data,  o_rt_data;
  logic [NB_DATA-1:0]   i_imm_ext,  o_imm_ext;
  logic [NB_SHAMT-1:0]  i_shamt,    o_shamt;
  logic [NB_FUNCT-1:0]  i_funct,    o_funct;
  logic [NB_REG-1:0]    i_rs_addr,  o_rs_addr;
  logic [NB_REG-1:0]    i_rt_addr,  o_rt_addr;
  logic [NB_REG-1:0]    i_rd_addr,  o_rd_addr;
  logic [NB_ALU_OP-1:0] i_alu_op,   o_alu_op;
  logic i_alu_src,    o_alu_src;
  logic i_mem_read,   o_mem_read;
  logic i_mem_write,  o_mem_write;
  logic i_mem_to_reg, o_mem_to_reg;
  logic i_reg_write,  o_reg_write;
  logic i_mem_unsigned, o_mem_unsigned;
  logic [1:0] i_reg_dst,   o_reg_dst;
  logic [1:0] i_mem_width, o_mem_width;
  logic [NB_CNT-1:0] o_bubble_cnt;
  logic [NB_CNT-1:0] o_flush_cnt;

  // ID stage / testbench side
  modport master (
    output i_valid, i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext, i_shamt, i_funct,
           i_rs_addr, i_rt_addr, i_rd_addr, i_alu_op, i_alu_src, i_mem_read, i_mem_write,
           i_mem_to_reg, i_reg_write, i_mem_unsigned, i_reg_dst, i_mem_width,
    input  o_valid, o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext, o_shamt, o_funct,
           o_rs_addr, o_rt_addr, o_rd_addr, o_alu_op, o_alu_src, o_mem_read, o_mem_write,
           o_mem_to_reg, o_reg_write, o_mem_unsigned, o_reg_dst, o_mem_width,
           o_bubble_cnt, o_flush_cnt
  );

  // Pipeline register side
  modport slave (
    input  i_valid, i_pc_plus4, i_rs_data, i_rt_data, i_imm_ext, i_shamt, i_funct,
           i_rs_addr, i_rt_addr, i_rd_addr, i_alu_op, i_alu_src, i_mem_read, i_mem_write,
           i_mem_to_reg, i_reg_write, i_mem_unsigned, i_reg_dst, i_mem_width,
    output o_valid, o_pc_plus4, o_rs_data, o_rt_data, o_imm_ext, o_shamt, o_funct,
           o_rs_addr, o_rt_addr, o_rd_addr, o_alu_op, o_alu_src, o_mem_read, o_mem_write,
           o_mem_to_reg, o_reg_write, o_mem_unsigned, o_reg_dst, o_mem_width,
           o_bubble_cnt, o_flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value; cleared only by reset.
module sat_counter #(
  parameter int NB_CNT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_inc,
  output logic [NB_CNT-1:0] o_cnt
);

  logic [NB_CNT-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_enable && i_inc && (cnt_q != {NB_CNT{1'b1}})) begin
      cnt_d = cnt_q + NB_CNT'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: loads ID fields, inserts bubbles on flush/stall, freezes on debug halt,
// and counts inserted bubbles for the debug unit.
module id_ex_pipe_reg
  import mips_pkg::*;
#(
  parameter int NB_CNT = NB_CNT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_stall,
  id_ex_pipe_reg_if.slave    bus
);

  id_ex_t id_fields;
  id_ex_t ex_q, ex_d;
  logic   bubble_inc, flush_inc;

  always_comb begin
    id_fields              = '0;
    id_fields.valid        = bus.i_valid;
    id_fields.pc_plus4     = bus.i_pc_plus4;
    id_fields.rs_data      = bus.i_rs_data;
    id_fields.rt_data      = bus.i_rt_data;
    id_fields.imm_ext      = bus.i_imm_ext;
    id_fields.shamt        = bus.i_shamt;
    id_fields.funct        = bus.i_funct;
    id_fields.rs_addr      = bus.i_rs_addr;
    id_fields.rt_addr      = bus.i_rt_addr;
    id_fields.rd_addr      = bus.i_rd_addr;
    id_fields.alu_op       = bus.i_alu_op;
    id_fields.alu_src      = bus.i_alu_src;
    id_fields.mem_read     = bus.i_mem_read;
    id_fields.mem_write    = bus.i_mem_write;
    id_fields.mem_to_reg   = bus.i_mem_to_reg;
    id_fields.reg_write    = bus.i_reg_write;
    id_fields.mem_unsigned = bus.i_mem_unsigned;
    id_fields.reg_dst      = bus.i_reg_dst;
    id_fields.mem_width    = bus.i_mem_width;
  end

  // Halt wins over everything; a flush/stall seen during halt is dropped, not remembered
  always_comb begin
    ex_d = ex_q;
    if (i_enable) begin
      if (i_flush || i_stall) begin
        ex_d = '0;
      end else begin
        ex_d = id_fields;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // A simultaneous flush and stall is one bubble, attributed to the flush
  assign flush_inc  = i_flush;
  assign bubble_inc = i_stall & ~i_flush;

  sat_counter #(.NB_CNT(NB_CNT)) u_bubble_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .i_inc    (bubble_inc),
    .o_cnt    (bus.o_bubble_cnt)
  );

  sat_counter #(.NB_CNT(NB_CNT)) u_flush_cnt (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (i_enable),
    .i_inc    (flush_inc),
    .o_cnt    (bus.o_flush_cnt)
  );

  assign bus.o_valid        = ex_q.valid;
  assign bus.o_pc_plus4     = ex_q.pc_plus4;
  assign bus.o_rs_data      = ex_q.rs_data;
  assign bus.o_rt_data      = ex_q.rt_data;
  assign bus.o_imm_ext      = ex_q.imm_ext;
  assign bus.o_shamt        = ex_q.shamt;
  assign bus.o_funct        = ex_q.funct;
  assign bus.o_rs_addr      = ex_q.rs_addr;
  assign bus.o_rt_addr      = ex_q.rt_addr;
  assign bus.o_rd_addr      = ex_q.rd_addr;
  assign bus.o_alu_op       = ex_q.alu_op;
  assign bus.o_alu_src      = ex_q.alu_src;
  assign bus.o_mem_read     = ex_q.mem_read;
  assign bus.o_mem_write    = ex_q.mem_write;
  assign bus.o_mem_to_reg   = ex_q.mem_to_reg;
  assign bus.o_reg_write    = ex_q.reg_write;
  assign bus.o_mem_unsigned = ex_q.mem_unsigned;
  assign bus.o_reg_dst      = ex_q.reg_dst;
  assign bus.o_mem_width    = ex_q.mem_width;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg with 2-bit counters so saturation is reachable quickly.
module tb_id_ex_pipe_reg;
  import mips_pkg::*;

  localparam int TB_NB_CNT = 2;
  localparam int N_VEC     = 17;

  typedef struct {
    logic   en;
    logic   fl;
    logic   st;
    id_ex_t in;
    id_ex_t exp;
    logic [TB_NB_CNT-1:0] exp_b;
    logic [TB_NB_CNT-1:0] exp_f;
  } vec_t;

  logic clk;
  logic rst_n;
  logic enable, flush, stall;
  int   n_cmp;
  int   n_err;

  id_ex_pipe_reg_if #(.NB_CNT(TB_NB_CNT)) bus ();

  id_ex_pipe_reg #(.NB_CNT(TB_NB_CNT)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_enable (enable),
    .i_flush  (flush),
    .i_stall  (stall),
    .bus      (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  task automatic drive_in(input id_ex_t p);
    bus.i_valid        = p.valid;
    bus.i_pc_plus4     = p.pc_plus4;
    bus.i_rs_data      = p.rs_data;
    bus.i_rt_data      = p.rt_data;
    bus.i_imm_ext      = p.imm_ext;
    bus.i_shamt        = p.shamt;
    bus.i_funct        = p.funct;
    bus.i_rs_addr      = p.rs_addr;
    bus.i_rt_addr      = p.rt_addr;
    bus.i_rd_addr      = p.rd_addr;
    bus.i_alu_op       = p.alu_op;
    bus.i_alu_src      = p.alu_src;
    bus.i_mem_read     = p.mem_read;
    bus.i_mem_write    = p.mem_write;
    bus.i_mem_to_reg   = p.mem_to_reg;
    bus.i_reg_write    = p.reg_write;
    bus.i_mem_unsigned = p.mem_unsigned;
    bus.i_reg_dst      = p.reg_dst;
    bus.i_mem_width    = p.mem_width;
  endtask

  function automatic id_ex_t get_out();
    id_ex_t r;
    r.valid        = bus.o_valid;
    r.pc_plus4     = bus.o_pc_plus4;
    r.rs_data      = bus.o_rs_data;
    r.rt_data      = bus.o_rt_data;
    r.imm_ext      = bus.o_imm_ext;
    r.shamt        = bus.o_shamt;
    r.funct        = bus.o_funct;
    r.rs_addr      = bus.o_rs_addr;
    r.rt_addr      = bus.o_rt_addr;
    r.rd_addr      = bus.o_rd_addr;
    r.alu_op       = bus.o_alu_op;
    r.alu_src      = bus.o_alu_src;
    r.mem_read     = bus.o_mem_read;
    r.mem_write    = bus.o_mem_write;
    r.mem_to_reg   = bus.o_mem_to_reg;
    r.reg_write    = bus.o_reg_write;
    r.mem_unsigned = bus.o_mem_unsigned;
    r.reg_dst      = bus.o_reg_dst;
    r.mem_width    = bus.o_mem_width;
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input id_ex_t exp_p,
                       input logic [TB_NB_CNT-1:0] eb, input logic [TB_NB_CNT-1:0] ef);
    id_ex_t act;
    act = get_out();
    n_cmp++;
    if (act !== exp_p) begin
      n_err++;
      $display("FAIL %s payload: got %h expected %h", nm, act, exp_p);
    end
    n_cmp++;
    if (bus.o_bubble_cnt !== eb) begin
      n_err++;
      $display("FAIL %s bubble_cnt: got %0d expected %0d", nm, bus.o_bubble_cnt, eb);
    end
    n_cmp++;
    if (bus.o_flush_cnt !== ef) begin
      n_err++;
      $display("FAIL %s flush_cnt: got %0d expected %0d", nm, bus.o_flush_cnt, ef);
    end
  endtask

  // ---------------- stimulus ----------------
  id_ex_t p_a, p_b, p_c, p_d, p_e, bub;
  vec_t   vecs [N_VEC];

  task automatic set_vec(input int idx, input logic en, input logic fl, input logic st,
                         input id_ex_t in, input id_ex_t exp,
                         input logic [TB_NB_CNT-1:0] eb, input logic [TB_NB_CNT-1:0] ef);
    vecs[idx].en    = en;
    vecs[idx].fl    = fl;
    vecs[idx].st    = st;
    vecs[idx].in    = in;
    vecs[idx].exp   = exp;
    vecs[idx].exp_b = eb;
    vecs[idx].exp_f = ef;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bub   = '0;

    // R-type SUB: rs=5, rt=3
    p_a = '0;
    p_a.valid = 1'b1;  p_a.pc_plus4 = 32'h0000_0104;
    p_a.rs_data = 32'h0000_0005;  p_a.rt_data = 32'h0000_0003;
    p_a.funct = 6'b100010;  p_a.alu_op = ALU_OP_R_TYPE;  p_a.reg_write = 1'b1;
    p_a.rs_addr = 5'd1;  p_a.rt_addr = 5'd2;  p_a.rd_addr = 5'd3;
    p_a.reg_dst = REG_DST_RD;  p_a.mem_width = MEM_WORD;

    // LHU
    p_b = '0;
    p_b.valid = 1'b1;  p_b.pc_plus4 = 32'h0000_0108;
    p_b.rs_data = 32'h0000_1000;  p_b.rt_data = 32'h0000_0077;  p_b.imm_ext = 32'h0000_0010;
    p_b.rs_addr = 5'd7;  p_b.rt_addr = 5'd8;  p_b.alu_op = ALU_OP_LOAD_STORE;
    p_b.alu_src = 1'b1;  p_b.mem_read = 1'b1;  p_b.mem_to_reg = 1'b1;  p_b.reg_write = 1'b1;
    p_b.mem_unsigned = 1'b1;  p_b.mem_width = MEM_HALF;  p_b.reg_dst = REG_DST_RT;

    // SB
    p_c = '0;
    p_c.valid = 1'b1;  p_c.pc_plus4 = 32'h0000_010C;
    p_c.rs_data = 32'h0000_2000;  p_c.rt_data = 32'hCAFE_BABE;  p_c.imm_ext = 32'hFFFF_FFFC;
    p_c.rs_addr = 5'd9;  p_c.rt_addr = 5'd10;  p_c.alu_src = 1'b1;  p_c.mem_write = 1'b1;
    p_c.mem_width = MEM_BYTE;

    // every bit set
    p_d = '1;

    // not-valid slot: data present, control zero
    p_e = '0;
    p_e.pc_plus4 = 32'h0000_0200;  p_e.rs_data = 32'hDEAD_BEEF;  p_e.rt_data = 32'h1234_5678;
    p_e.imm_ext = 32'hFFFF_FF80;  p_e.shamt = 5'd7;  p_e.rs_addr = 5'd4;  p_e.rt_addr = 5'd5;
    p_e.rd_addr = 5'd6;

    //       idx en    fl    st    in   exp  b  f
    set_vec( 0, 1'b1, 1'b0, 1'b0, p_a, p_a, 0, 0);  // pass-through
    set_vec( 1, 1'b1, 1'b0, 1'b1, p_b, bub, 1, 0);  // stall 1
    set_vec( 2, 1'b1, 1'b0, 1'b1, p_b, bub, 2, 0);  // stall 2
    set_vec( 3, 1'b1, 1'b0, 1'b0, p_b, p_b, 2, 0);  // reload after stall
    set_vec( 4, 1'b1, 1'b1, 1'b1, p_c, bub, 2, 1);  // flush+stall: flush only
    set_vec( 5, 1'b1, 1'b0, 1'b0, p_d, p_d, 2, 1);
    set_vec( 6, 1'b0, 1'b1, 1'b0, p_c, p_d, 2, 1);  // frozen
    set_vec( 7, 1'b0, 1'b0, 1'b1, p_a, p_d, 2, 1);  // frozen
    set_vec( 8, 1'b0, 1'b1, 1'b0, p_e, p_d, 2, 1);  // frozen
    set_vec( 9, 1'b1, 1'b0, 1'b0, p_e, p_e, 2, 1);  // flush not deferred
    set_vec(10, 1'b1, 1'b0, 1'b0, p_c, p_c, 2, 1);
    set_vec(11, 1'b1, 1'b1, 1'b0, p_c, bub, 2, 2);
    set_vec(12, 1'b1, 1'b0, 1'b1, p_a, bub, 3, 2);
    set_vec(13, 1'b1, 1'b0, 1'b1, p_a, bub, 3, 2);  // bubble_cnt saturated
    set_vec(14, 1'b1, 1'b1, 1'b0, p_a, bub, 3, 3);
    set_vec(15, 1'b1, 1'b1, 1'b0, p_a, bub, 3, 3);  // flush_cnt saturated
    set_vec(16, 1'b1, 1'b0, 1'b0, p_a, p_a, 3, 3);

    // reset with busy inputs
    rst_n  = 1'b0;
    enable = 1'b1;
    flush  = 1'b1;
    stall  = 1'b1;
    drive_in(p_d);
    repeat (2) @(posedge clk);
    #1;
    check("reset", bub, 0, 0);
    n_cmp++;
    if (bus.o_alu_op !== 4'b0000) begin
      n_err++;
      $display("FAIL reset alu_op: got %b expected 0000", bus.o_alu_op);
    end

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < N_VEC; i++) begin
      if (i != 0) @(negedge clk);
      enable = vecs[i].en;
      flush  = vecs[i].fl;
      stall  = vecs[i].st;
      drive_in(vecs[i].in);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].exp_b, vecs[i].exp_f);
    end

    // async reset pulse between edges
    @(negedge clk);
    enable = 1'b1;
    flush  = 1'b0;
    stall  = 1'b0;
    drive_in(p_b);
    rst_n = 1'b0;
    #1;
    check("async_rst", bub, 0, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_load", p_b, 0, 0);

    // five stalls into a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stall = 1'b1;
      drive_in(p_c);
      @(posedge clk);
      #1;
      check($sformatf("sat_stall%0d", i), bub, (i < 3) ? TB_NB_CNT'(i + 1) : 2'd3, 0);
    end
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk);
    #1;
    check("after_sat", p_c, 3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
